sync_correlator: RTL and testbench



---
 rtl/sync_correlator_if.sv | 25 ++
 rtl/sync_correlator.sv | 143 ++++++++++++++
 tb/tb_sync_correlator.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_correlator_if.sv
// Receive-side correlator bus: bit strobe, window and configuration in,
// sync pulse and peak report out.
interface sync_correlator_if #(
  parameter int SW_LEN = 64
);
  logic              p_1us;
  logic              rxbit;
  logic              searchWin;
  logic [SW_LEN-1:0] syncword;
  logic [6:0]        regi_corre_threshold;
  logic              corre_sync_p;
  logic [6:0]        corre_best;
  logic [3:0]        corre_lag;
  logic              corre_busy;

  modport master (
    output p_1us, rxbit, searchWin, syncword, regi_corre_threshold,
    input  corre_sync_p, corre_best, corre_lag, corre_busy
  );

  modport slave (
    input  p_1us, rxbit, searchWin, syncword, regi_corre_threshold,
    output corre_sync_p, corre_best, corre_lag, corre_busy
  );
endinterface

// File: rtl/sync_correlator.sv
// Access-code sync-word correlator with peak search. Bits shift in on the
// 1 us strobe; the matching-bit count is evaluated two cycles later, and a
// single sync pulse marks the best-matching position inside the window.
module sync_correlator #(
  parameter int SW_LEN    = 64,
  parameter int PEAK_HOLD = 1
) (
  input  logic                  clk_6M,
  input  logic                  rstz,
  sync_correlator_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    PEAK    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  // Number of positions where the received window agrees with the sync word.
  function automatic logic [6:0] match_count(input logic [SW_LEN-1:0] rx,
                                             input logic [SW_LEN-1:0] ref_w);
    logic [6:0] mism;
    mism = '0;
    for (int i = 0; i < SW_LEN; i++) begin
      mism = mism + {6'd0, rx[i] ^ ref_w[i]};
    end
    return 7'(SW_LEN) - mism;
  endfunction

  logic [SW_LEN-1:0] sr_p0;
  logic [6:0]        match_cnt;
  logic              p_1us_p1;
  logic              eval_p;

  state_t            state, state_nxt;
  logic [6:0]        best, best_nxt;
  logic [3:0]        age, age_nxt;
  logic              fire;

  logic              sync_p_r;
  logic [6:0]        best_out_r;
  logic [3:0]        lag_out_r;

  // Stage p0: shift register runs in every state so correlation is ready at window open.
  always_ff @(posedge clk_6M) begin
    if (rstz) begin
      sr_p0 <= '0;
    end else if (bus.p_1us) begin
      sr_p0 <= {bus.rxbit, sr_p0[SW_LEN-1:1]};
    end
  end

  // Stage p1/p2: match count one cycle after the shift; eval strobe aligned with it.
  always_ff @(posedge clk_6M) begin
    if (rstz) begin
      match_cnt <= '0;
      p_1us_p1  <= 1'b0;
      eval_p    <= 1'b0;
    end else begin
      match_cnt <= match_count(sr_p0, bus.syncword);
      p_1us_p1  <= bus.p_1us;
      eval_p    <= p_1us_p1;
    end
  end

  // Peak-search state register.
  always_ff @(posedge clk_6M) begin
    if (rstz) begin
      state <= IDLE;
      best  <= '0;
      age   <= '0;
    end else begin
      state <= state_nxt;
      best  <= best_nxt;
      age   <= age_nxt;
    end
  end

  // Next-state logic: window close beats a same-cycle evaluation; ties keep the earliest peak.
  always_comb begin
    state_nxt = state;
    best_nxt  = best;
    age_nxt   = age;
    fire      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.searchWin) state_nxt = SEARCH;
      end
      SEARCH: begin
        if (!bus.searchWin) begin
          state_nxt = IDLE;
        end else if (eval_p && (match_cnt >= bus.regi_corre_threshold)) begin
          state_nxt = PEAK;
          best_nxt  = match_cnt;
          age_nxt   = '0;
        end
      end
      PEAK: begin
        if (!bus.searchWin) begin
          fire      = 1'b1;
          state_nxt = HOLDOFF;
        end else if (eval_p) begin
          if (match_cnt > best) begin
            best_nxt = match_cnt;
            age_nxt  = '0;
          end else begin
            age_nxt = age + 4'd1;
            if (age_nxt == 4'(PEAK_HOLD)) begin
              fire      = 1'b1;
              state_nxt = HOLDOFF;
            end
          end
        end
      end
      HOLDOFF: begin
        if (!bus.searchWin) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pulse and peak report registered on fire; report holds until the next fire.
  always_ff @(posedge clk_6M) begin
    if (rstz) begin
      sync_p_r   <= 1'b0;
      best_out_r <= '0;
      lag_out_r  <= '0;
    end else begin
      sync_p_r <= fire;
      if (fire) begin
        best_out_r <= best_nxt;
        lag_out_r  <= age_nxt;
      end
    end
  end

  assign bus.corre_sync_p = sync_p_r;
  assign bus.corre_best   = best_out_r;
  assign bus.corre_lag    = lag_out_r;
  assign bus.corre_busy   = (state == PEAK) || (state == HOLDOFF);

endmodule

// File: tb/tb_sync_correlator.sv
// Bench for sync_correlator: directed scenarios plus randomized traffic,
// every cycle compared against a bit-history reference model.
module tb_sync_correlator;

  localparam int SW_LEN    = 64;
  localparam int PEAK_HOLD = 1;

  logic clk_6M = 1'b0;
  logic rstz   = 1'b1;

  sync_correlator_if #(.SW_LEN(SW_LEN)) bus ();

  sync_correlator #(.SW_LEN(SW_LEN), .PEAK_HOLD(PEAK_HOLD)) dut (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .bus    (bus.slave)
  );

  always #83 clk_6M = ~clk_6M;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int pulses = 0;
  int pulse_cyc = -1;
  int t0 = 0;

  logic [63:0] m_sw;
  logic [63:0] flip3, flip2;

  // reference model state
  typedef struct { int due; int cnt; } ev_t;
  bit  hist[$];
  ev_t evq[$];
  int  m_mode;   // 0 idle, 1 searching, 2 peak, 3 holdoff
  int  m_best, m_age, m_obest, m_olag;
  bit  m_pulse;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int score();
    int s = 0;
    for (int i = 0; i < SW_LEN; i++) if (hist[i] == m_sw[i]) s++;
    return s;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SW_LEN; i++) hist.push_back(1'b0);
    evq.delete();
    m_mode = 0; m_best = 0; m_age = 0; m_pulse = 0; m_obest = 0; m_olag = 0;
  endtask

  task automatic model_fire();
    m_pulse = 1; m_obest = m_best; m_olag = m_age; m_mode = 3;
  endtask

  // Advance model and DUT through one clock edge, then compare all outputs.
  task automatic step();
    bit ev;
    int c;
    int thr;
    ev = 0; c = 0;
    thr = int'(bus.regi_corre_threshold);
    if (rstz) begin
      model_reset();
    end else begin
      if (evq.size() > 0 && evq[0].due == cyc) begin
        ev = 1; c = evq[0].cnt; void'(evq.pop_front());
      end
      m_pulse = 0;
      case (m_mode)
        0: if (bus.searchWin) m_mode = 1;
        1: begin
          if (!bus.searchWin) m_mode = 0;
          else if (ev && c >= thr) begin m_mode = 2; m_best = c; m_age = 0; end
        end
        2: begin
          if (!bus.searchWin) model_fire();
          else if (ev) begin
            if (c > m_best) begin m_best = c; m_age = 0; end
            else begin
              m_age++;
              if (m_age == PEAK_HOLD) model_fire();
            end
          end
        end
        default: if (!bus.searchWin) m_mode = 0;
      endcase
      if (bus.p_1us) begin
        void'(hist.pop_front());
        hist.push_back(bus.rxbit);
        evq.push_back('{cyc + 2, score()});
      end
    end
    @(posedge clk_6M);
    #1;
    cyc++;
    chk("sync_p", bus.corre_sync_p, m_pulse);
    chk("best",   bus.corre_best, m_obest);
    chk("lag",    bus.corre_lag, m_olag);
    chk("busy",   bus.corre_busy, (m_mode >= 2));
    if (bus.corre_sync_p) begin pulses++; pulse_cyc = cyc; end
  endtask

  task automatic send_bit(input logic b);
    bus.p_1us = 1'b1; bus.rxbit = b; t0 = cyc;
    step();
    bus.p_1us = 1'b0;
    repeat (5) step();
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic send_word(input logic [63:0] w, input logic [63:0] fl, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[i] ^ fl[i]);
  endtask

  task automatic idle_steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    #100000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [63:0] fm;
    int k;
    int thr_tab [8];
    thr_tab = '{0, 58, 60, 61, 62, 63, 64, 70};
    m_sw  = 64'h4E1C_3A5F_9B27_D0C1;
    flip3 = (64'd1 << 5) | (64'd1 << 30) | (64'd1 << 50);
    flip2 = (64'd1 << 5) | (64'd1 << 30);
    bus.p_1us = 1'b0; bus.rxbit = 1'b0; bus.searchWin = 1'b0;
    bus.syncword = m_sw; bus.regi_corre_threshold = 7'd64;
    model_reset();

    // reset state
    rstz = 1'b1;
    idle_steps(3);
    chk("rst_sync_p", bus.corre_sync_p, 0);
    chk("rst_busy", bus.corre_busy, 0);
    rstz = 1'b0;

    // exact word, threshold 64
    bus.searchWin = 1'b1; pulses = 0;
    send_rand(10);
    send_word(m_sw, 64'd0, 64);
    send_rand(4);
    chk("exact_pulses", pulses, 1);
    chk("exact_latency", pulse_cyc - t0 + 4 * 6, 9);
    chk("exact_best", bus.corre_best, 64);
    chk("exact_lag", bus.corre_lag, 1);
    bus.searchWin = 1'b0; idle_steps(4);

    // three flipped bits, threshold 61
    bus.regi_corre_threshold = 7'd61; bus.searchWin = 1'b1; pulses = 0;
    send_word(m_sw, flip3, 64);
    send_rand(4);
    chk("flip3_t61_pulses", pulses, 1);
    chk("flip3_t61_best", bus.corre_best, 61);
    bus.searchWin = 1'b0; idle_steps(4);

    // three flipped bits, threshold 62: no pulse, report held
    bus.regi_corre_threshold = 7'd62; bus.searchWin = 1'b1; pulses = 0;
    send_word(m_sw, flip3, 64);
    send_rand(4);
    chk("flip3_t62_pulses", pulses, 0);
    chk("flip3_t62_best", bus.corre_best, 61);
    bus.searchWin = 1'b0; idle_steps(4);

    // word with window closed, then window over random data
    bus.regi_corre_threshold = 7'd64; pulses = 0;
    send_word(m_sw, 64'd0, 64);
    bus.searchWin = 1'b1;
    send_rand(20);
    chk("closedwin_pulses", pulses, 0);
    chk("closedwin_busy", bus.corre_busy, 0);
    bus.searchWin = 1'b0; idle_steps(3);

    // window drops one cycle after entering PEAK at count 62
    bus.regi_corre_threshold = 7'd62; bus.searchWin = 1'b1; pulses = 0;
    send_word(m_sw, flip2, 63);
    bus.p_1us = 1'b1; bus.rxbit = m_sw[63];
    step();
    bus.p_1us = 1'b0;
    step(); step();
    chk("drop_busy", bus.corre_busy, 1);
    bus.searchWin = 1'b0;
    step();
    chk("drop_pulse", bus.corre_sync_p, 1);
    chk("drop_best", bus.corre_best, 62);
    chk("drop_lag", bus.corre_lag, 0);
    idle_steps(4);

    // two words in one window, then a third after reopening
    bus.regi_corre_threshold = 7'd64; bus.searchWin = 1'b1; pulses = 0;
    send_word(m_sw, 64'd0, 64); send_rand(8);
    send_word(m_sw, 64'd0, 64); send_rand(8);
    chk("twoword_pulses", pulses, 1);
    bus.searchWin = 1'b0; idle_steps(3);
    bus.searchWin = 1'b1;
    send_word(m_sw, 64'd0, 64); send_rand(8);
    chk("reopen_pulses", pulses, 2);
    bus.searchWin = 1'b0; idle_steps(3);

    // reset one cycle before the expected pulse
    bus.searchWin = 1'b1; pulses = 0;
    send_word(m_sw, 64'd0, 63);
    bus.p_1us = 1'b1; bus.rxbit = m_sw[63];
    step();
    bus.p_1us = 1'b0;
    idle_steps(5);
    bus.p_1us = 1'b1; bus.rxbit = 1'($urandom_range(0, 1));
    step();
    bus.p_1us = 1'b0;
    step();
    rstz = 1'b1;
    step();
    rstz = 1'b0;
    chk("rstpend_pulse", bus.corre_sync_p, 0);
    chk("rstpend_best", bus.corre_best, 0);
    chk("rstpend_lag", bus.corre_lag, 0);
    chk("rstpend_busy", bus.corre_busy, 0);
    idle_steps(4);
    chk("rstpend_pulses", pulses, 0);
    send_word(m_sw, 64'd0, 64); send_rand(4);
    chk("afterrst_pulses", pulses, 1);
    chk("afterrst_best", bus.corre_best, 64);
    bus.searchWin = 1'b0; idle_steps(3);

    // randomized traffic checked cycle by cycle against the model
    for (int it = 0; it < 12; it++) begin
      bus.regi_corre_threshold = 7'(thr_tab[$urandom_range(0, 7)]);
      bus.searchWin = 1'b1;
      send_rand($urandom_range(0, 20));
      if ($urandom_range(0, 3) != 0) begin
        fm = '0;
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) fm[$urandom_range(0, 63)] = 1'b1;
        for (int b = 0; b < 64; b++) begin
          if ($urandom_range(0, 31) == 0) bus.searchWin = ~bus.searchWin;
          send_bit(m_sw[b] ^ fm[b]);
        end
      end
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 7) == 0) bus.searchWin = ~bus.searchWin;
        send_bit(1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 5) == 0) begin
        rstz = 1'b1; step(); rstz = 1'b0;
      end
      bus.searchWin = 1'b0;
      idle_steps($urandom_range(1, 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
